// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl: SPI master transaction sequencer.
// Accepts one frame command, asserts the selected chip-select for a programmable
// setup time, runs the external clock generator through busy/st/last, and uses
// its edge strobes to shift MOSI and sample MISO. After the hold time it releases
// chip-select and returns the received word on a valid/ready response port.
//
// Ports:
//   clk_i, rst_n_i                 clock, synchronous active-low reset
//   cmd_valid_i/cmd_ready_o        command handshake
//   cmd_len_i/cs_i/lsb_i/tx_i      frame length-1, CS index, bit order, tx word
//   cpol_i, cpha_i                 SPI mode (static while a frame is active)
//   dly_i                          CS setup/hold length minus one
//   abort_i                        drop the current frame, no response
//   sck_i, pos_edge_i, neg_edge_i  clock generator level and edge strobes
//   busy_o, st_o, last_o           clock generator controls
//   cs_n_o                         active-low chip-selects
//   mosi_o, miso_i                 serial data
//   rsp_valid_o/rsp_ready_i        response handshake
//   rsp_rx_o                       received word, right-justified
module spi_xfer_ctrl #(
    parameter  int unsigned CS_NUM = 4,
    localparam int unsigned CS_W   = (CS_NUM > 1) ? $clog2(CS_NUM) : 1,
    localparam int unsigned LEN_W  = 5,
    localparam int unsigned DATA_W = 32,
    localparam int unsigned DLY_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [LEN_W-1:0]  cmd_len_i,
    input  logic [CS_W-1:0]   cmd_cs_i,
    input  logic              cmd_lsb_i,
    input  logic [DATA_W-1:0] cmd_tx_i,
    input  logic              cpol_i,
    input  logic              cpha_i,
    input  logic [DLY_W-1:0]  dly_i,
    input  logic              abort_i,
    input  logic              sck_i,
    input  logic              pos_edge_i,
    input  logic              neg_edge_i,
    output logic              busy_o,
    output logic              st_o,
    output logic              last_o,
    output logic [CS_NUM-1:0] cs_n_o,
    output logic              mosi_o,
    input  logic              miso_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_rx_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_XFER,
        S_HOLD,
        S_RESP
    } state_e;

    state_e              state_q, state_d;
    logic [DLY_W-1:0]    cnt_q, cnt_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [CS_W-1:0]     cs_q, cs_d;
    logic                lsb_q, lsb_d;
    logic [DATA_W-1:0]   tx_sr_q, tx_sr_d;
    logic [DATA_W-1:0]   rx_sr_q, rx_sr_d;
    logic [LEN_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic                lead_seen_q, lead_seen_d;

    logic                cmd_ready_q, cmd_ready_d;
    logic                busy_q, busy_d;
    logic                st_q, st_d;
    logic                last_q, last_d;
    logic [CS_NUM-1:0]   cs_n_q, cs_n_d;
    logic                mosi_q, mosi_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rx_q, rsp_rx_d;

    logic                lead_edge;
    logic                trail_edge;
    logic                sample_en;
    logic                shift_en;
    logic                last_hit;
    logic [LEN_W-1:0]    bit_idx;

    // State and output registers
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            len_q       <= '0;
            cs_q        <= '0;
            lsb_q       <= 1'b0;
            tx_sr_q     <= '0;
            rx_sr_q     <= '0;
            bit_cnt_q   <= '0;
            lead_seen_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            st_q        <= 1'b0;
            last_q      <= 1'b0;
            cs_n_q      <= '1;
            mosi_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rx_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            cs_q        <= cs_d;
            lsb_q       <= lsb_d;
            tx_sr_q     <= tx_sr_d;
            rx_sr_q     <= rx_sr_d;
            bit_cnt_q   <= bit_cnt_d;
            lead_seen_q <= lead_seen_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            st_q        <= st_d;
            last_q      <= last_d;
            cs_n_q      <= cs_n_d;
            mosi_q      <= mosi_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rx_q    <= rsp_rx_d;
        end
    end

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        cs_d        = cs_q;
        lsb_d       = lsb_q;
        tx_sr_d     = tx_sr_q;
        rx_sr_d     = rx_sr_q;
        bit_cnt_d   = bit_cnt_q;
        lead_seen_d = lead_seen_q;
        rsp_rx_d    = rsp_rx_q;
        last_hit    = 1'b0;

        // Mode decode: leading edge leaves the idle level
        lead_edge  = cpol_i ? neg_edge_i : pos_edge_i;
        trail_edge = cpol_i ? pos_edge_i : neg_edge_i;
        sample_en  = cpha_i ? trail_edge : lead_edge;
        // With cpha=1 the first bit is already on MOSI, so the first leading edge must not shift
        shift_en   = cpha_i ? (lead_edge && lead_seen_q) : trail_edge;
        bit_idx    = lsb_q ? bit_cnt_q : (len_q - bit_cnt_q);

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    len_d       = cmd_len_i;
                    cs_d        = cmd_cs_i;
                    lsb_d       = cmd_lsb_i;
                    tx_sr_d     = cmd_tx_i;
                    rx_sr_d     = '0;
                    bit_cnt_d   = '0;
                    lead_seen_d = 1'b0;
                    cnt_d       = dly_i;
                    state_d     = S_SETUP;
                end
            end
            S_SETUP: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = S_XFER;
                end else begin
                    cnt_d = cnt_q - DLY_W'(1);
                end
            end
            S_XFER: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else begin
                    // Samples after the final bit are ignored
                    if (sample_en && !last_q) begin
                        rx_sr_d[bit_idx] = miso_i;
                        if (bit_cnt_q == len_q) begin
                            last_hit = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + LEN_W'(1);
                        end
                    end
                    if (shift_en) begin
                        tx_sr_d = lsb_q ? {1'b0, tx_sr_q[DATA_W-1:1]}
                                        : {tx_sr_q[DATA_W-2:0], 1'b0};
                    end
                    if (lead_edge) begin
                        lead_seen_d = 1'b1;
                    end
                    // Leave only once the generator has parked SCK at its idle level
                    if (last_q && (sck_i == cpol_i)) begin
                        cnt_d   = dly_i;
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    rsp_rx_d = rx_sr_q;
                    state_d  = S_RESP;
                end else begin
                    cnt_d = cnt_q - DLY_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered, so they are decoded from the next state
        cmd_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d == S_XFER);
        st_d        = (state_d == S_SETUP) && (cnt_d == '0);
        last_d      = (state_d == S_XFER) && (last_q || last_hit);
        rsp_valid_d = (state_d == S_RESP);
        mosi_d      = lsb_d ? tx_sr_d[0] : tx_sr_d[len_d];

        // Out-of-range CS indices match no line; the frame still runs
        cs_n_d = '1;
        if ((state_d == S_SETUP) || (state_d == S_XFER) || (state_d == S_HOLD)) begin
            for (int unsigned i = 0; i < CS_NUM; i++) begin
                if (cs_d == CS_W'(i)) begin
                    cs_n_d[i] = 1'b0;
                end
            end
        end
    end

    assign cmd_ready_o = cmd_ready_q;
    assign busy_o      = busy_q;
    assign st_o        = st_q;
    assign last_o      = last_q;
    assign cs_n_o      = cs_n_q;
    assign mosi_o      = mosi_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rx_o    = rsp_rx_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// tb_spi_xfer_ctrl: directed bench for spi_xfer_ctrl with a behavioural clock
// generator (divider 0), MISO loopback/tie options and a response scoreboard.
module tb_spi_xfer_ctrl;

    localparam int unsigned CS_NUM = 4;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [4:0]  cmd_len_i;
    logic [1:0]  cmd_cs_i;
    logic        cmd_lsb_i;
    logic [31:0] cmd_tx_i;
    logic        cpol_i;
    logic        cpha_i;
    logic [7:0]  dly_i;
    logic        abort_i;
    logic        sck_i;
    logic        pos_edge_i;
    logic        neg_edge_i;
    logic        busy_o;
    logic        st_o;
    logic        last_o;
    logic [3:0]  cs_n_o;
    logic        mosi_o;
    logic        miso_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rx_o;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int          miso_mode = 0;   // 0 loopback, 1 tied high, 2 tied low
    logic [31:0] exp_q[$];

    always #5 clk_i = ~clk_i;

    spi_xfer_ctrl #(.CS_NUM(CS_NUM)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_len_i   (cmd_len_i),
        .cmd_cs_i    (cmd_cs_i),
        .cmd_lsb_i   (cmd_lsb_i),
        .cmd_tx_i    (cmd_tx_i),
        .cpol_i      (cpol_i),
        .cpha_i      (cpha_i),
        .dly_i       (dly_i),
        .abort_i     (abort_i),
        .sck_i       (sck_i),
        .pos_edge_i  (pos_edge_i),
        .neg_edge_i  (neg_edge_i),
        .busy_o      (busy_o),
        .st_o        (st_o),
        .last_o      (last_o),
        .cs_n_o      (cs_n_o),
        .mosi_o      (mosi_o),
        .miso_i      (miso_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_rx_o    (rsp_rx_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Divider-0 clock generator: toggles SCK every busy cycle until last_o with SCK idle
    task automatic drive_gen();
        pos_edge_i = 1'b0;
        neg_edge_i = 1'b0;
        if (!busy_o) begin
            sck_i = cpol_i;
        end else if (!(last_o && (sck_i == cpol_i))) begin
            sck_i      = ~sck_i;
            pos_edge_i = sck_i;
            neg_edge_i = ~sck_i;
        end
        miso_i = (miso_mode == 0) ? mosi_o : (miso_mode == 1);
    endtask

    // kill: 0 normal, 1 abort on 3rd sample strobe, 2 reset on 3rd sample strobe
    task automatic run_frame(input string tag, input logic [4:0] len, input logic [1:0] cs,
                             input logic lsb, input logic [31:0] tx, input logic pol,
                             input logic pha, input logic [7:0] dly, input int mmode,
                             input int kill, input int rdy_delay);
        logic [31:0] mask;
        logic [31:0] exp_rx;
        logic [31:0] held_rx;
        logic [3:0]  cs_pat;
        logic        cs_bad;
        logic        done;
        logic        smp;
        int          first_cs, st_cnt, st_rel, first_busy, last_busy;
        int          cs_low, last_cs, rsp_rel, samp, wait_cnt, idx;

        mask     = (len == 5'd31) ? 32'hFFFF_FFFF : ((32'd1 << (int'(len) + 1)) - 32'd1);
        exp_rx   = (mmode == 0) ? (tx & mask) : ((mmode == 1) ? mask : 32'h0);
        cs_pat   = 4'hF;
        cs_pat[cs] = 1'b0;
        cs_bad   = 1'b0;
        done     = 1'b0;
        held_rx  = '0;
        first_cs = -1; st_cnt = 0; st_rel = -1; first_busy = -1; last_busy = -1;
        cs_low = 0; last_cs = -1; rsp_rel = -1; samp = 0; wait_cnt = 0;

        chk({tag, ".ready_idle"}, 32'(cmd_ready_o), 32'd1);
        cpol_i      = pol;
        cpha_i      = pha;
        dly_i       = dly;
        miso_mode   = mmode;
        cmd_valid_i = 1'b1;
        cmd_len_i   = len;
        cmd_cs_i    = cs;
        cmd_lsb_i   = lsb;
        cmd_tx_i    = tx;
        rsp_ready_i = (rdy_delay == 0);
        drive_gen();
        if (kill == 0) exp_q.push_back(exp_rx);
        tick();
        cmd_valid_i = 1'b0;

        for (int k = 1; k <= 300 && !done; k++) begin
            if (cs_n_o != 4'hF) begin
                if (first_cs < 0) first_cs = k;
                cs_low++;
                last_cs = k;
                if (cs_n_o != cs_pat) cs_bad = 1'b1;
            end
            if (st_o) begin
                st_cnt++;
                st_rel = k;
            end
            if (busy_o) begin
                if (first_busy < 0) first_busy = k;
                last_busy = k;
            end
            if (rsp_valid_o) begin
                if (rsp_rel < 0) begin
                    rsp_rel = k;
                    held_rx = rsp_rx_o;
                    chk({tag, ".cs_released_resp"}, 32'(cs_n_o), 32'hF);
                    if (rdy_delay > 0) begin
                        // Another command waits while the response is stalled
                        cmd_valid_i = 1'b1;
                        cmd_len_i   = 5'd3;
                        cmd_tx_i    = 32'hFFFF_FFFF;
                    end
                end else begin
                    chk({tag, ".rsp_stable"}, rsp_rx_o, held_rx);
                end
                chk({tag, ".ready_low_resp"}, 32'(cmd_ready_o), 32'd0);
                rsp_ready_i = (wait_cnt >= rdy_delay);
                wait_cnt++;
            end

            drive_gen();
            smp = busy_o && (pha ? (pol ? pos_edge_i : neg_edge_i)
                                 : (pol ? neg_edge_i : pos_edge_i));
            if (smp) begin
                idx = lsb ? samp : (int'(len) - samp);
                chk($sformatf("%s.mosi_bit%0d", tag, samp), 32'(mosi_o), 32'(tx[idx]));
                samp++;
            end

            if (kill != 0 && smp && samp == 3) begin
                if (kill == 1) abort_i = 1'b1;
                else           rst_n_i = 1'b0;
                tick();
                abort_i = 1'b0;
                rst_n_i = 1'b1;
                chk({tag, ".kill_ready"}, 32'(cmd_ready_o), 32'd1);
                chk({tag, ".kill_cs"},    32'(cs_n_o),      32'hF);
                chk({tag, ".kill_busy"},  32'(busy_o),      32'd0);
                chk({tag, ".kill_st"},    32'(st_o),        32'd0);
                chk({tag, ".kill_last"},  32'(last_o),      32'd0);
                if (kill == 2) begin
                    chk({tag, ".rst_mosi"}, 32'(mosi_o), 32'd0);
                    chk({tag, ".rst_rx"},   rsp_rx_o,    32'd0);
                end
                for (int j = 0; j < 6; j++) begin
                    chk({tag, ".no_rsp"}, 32'(rsp_valid_o), 32'd0);
                    drive_gen();
                    tick();
                end
                done = 1'b1;
            end else if (rsp_valid_o && rsp_ready_i) begin
                if (exp_q.size() == 0) begin
                    chk({tag, ".rsp_unexpected"}, 32'd1, 32'd0);
                end else begin
                    chk({tag, ".rsp_rx"}, rsp_rx_o, exp_q.pop_front());
                end
                done = 1'b1;
            end
            tick();
        end

        chk({tag, ".completed"}, 32'(done), 32'd1);
        if (kill == 0) begin
            chk({tag, ".cs_first"},   32'(first_cs),   32'd1);
            chk({tag, ".cs_pattern"}, 32'(cs_bad),     32'd0);
            chk({tag, ".st_count"},   32'(st_cnt),     32'd1);
            chk({tag, ".st_cycle"},   32'(st_rel),     32'(int'(dly) + 1));
            chk({tag, ".busy_first"}, 32'(first_busy), 32'(int'(dly) + 2));
            chk({tag, ".samples"},    32'(samp),       32'(int'(len) + 1));
            chk({tag, ".hold_end"},   32'(last_cs),    32'(last_busy + int'(dly) + 1));
            chk({tag, ".cs_low_len"}, 32'(cs_low),
                32'(last_busy - first_busy + 1 + 2 * (int'(dly) + 1)));
            chk({tag, ".rsp_rise"},   32'(rsp_rel),    32'(last_cs + 1));
            chk({tag, ".idle_after"}, 32'(rsp_valid_o), 32'd0);
        end
        rsp_ready_i = 1'b1;
    endtask

    initial begin
        rst_n_i     = 1'b0;
        cmd_valid_i = 1'b0;
        cmd_len_i   = '0;
        cmd_cs_i    = '0;
        cmd_lsb_i   = 1'b0;
        cmd_tx_i    = '0;
        cpol_i      = 1'b0;
        cpha_i      = 1'b0;
        dly_i       = '0;
        abort_i     = 1'b0;
        sck_i       = 1'b0;
        pos_edge_i  = 1'b0;
        neg_edge_i  = 1'b0;
        miso_i      = 1'b0;
        rsp_ready_i = 1'b1;

        repeat (3) tick();
        chk("reset.ready",  32'(cmd_ready_o), 32'd1);
        chk("reset.cs",     32'(cs_n_o),      32'hF);
        chk("reset.busy",   32'(busy_o),      32'd0);
        chk("reset.st",     32'(st_o),        32'd0);
        chk("reset.last",   32'(last_o),      32'd0);
        chk("reset.mosi",   32'(mosi_o),      32'd0);
        chk("reset.rvalid", 32'(rsp_valid_o), 32'd0);
        chk("reset.rx",     rsp_rx_o,         32'd0);
        rst_n_i = 1'b1;
        tick();

        //        tag         len    cs    lsb   tx             pol   pha   dly   miso kill rdy
        run_frame("m0_a5",    5'd7,  2'd0, 1'b0, 32'h0000_00A5, 1'b0, 1'b0, 8'd2, 0, 0, 0);
        run_frame("m3_lsb",   5'd15, 2'd1, 1'b1, 32'h0000_1234, 1'b1, 1'b1, 8'd1, 1, 0, 0);
        run_frame("m1_32b",   5'd31, 2'd2, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b1, 8'd3, 0, 0, 0);
        run_frame("m2_32b",   5'd31, 2'd0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 8'd0, 0, 0, 0);
        run_frame("len0_cs3", 5'd0,  2'd3, 1'b0, 32'h0000_0001, 1'b0, 1'b0, 8'd0, 0, 0, 0);
        run_frame("abort",    5'd7,  2'd1, 1'b0, 32'h0000_003C, 1'b0, 1'b0, 8'd1, 0, 1, 0);
        run_frame("post_abt", 5'd11, 2'd2, 1'b1, 32'h0000_0ABC, 1'b0, 1'b1, 8'd2, 2, 0, 0);
        run_frame("stall",    5'd7,  2'd0, 1'b0, 32'h0000_005A, 1'b0, 1'b0, 8'd1, 0, 0, 10);
        run_frame("b2b",      5'd3,  2'd1, 1'b0, 32'h0000_0009, 1'b1, 1'b1, 8'd0, 0, 0, 0);
        run_frame("midreset", 5'd15, 2'd3, 1'b0, 32'h0000_F0F0, 1'b1, 1'b0, 8'd1, 0, 2, 0);
        run_frame("post_rst", 5'd4,  2'd0, 1'b0, 32'h0000_0015, 1'b0, 1'b0, 8'd2, 1, 0, 0);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_xfer_ctrl.md
# spi_xfer_ctrl

Transaction sequencer for the SPI master. It accepts one frame command at a time and asserts the selected chip-select with a programmable setup delay. It then drives the busy/start/last controls of the SPI clock generator and uses the generator's edge strobes to shift MOSI and sample MISO. After a hold delay it releases chip-select and returns the received word through a valid/ready response port.

## Interface
- CS_NUM, 4: number of chip-select lines; CS_W = $clog2(CS_NUM), minimum 1.
- clk_i  in  1  system clock.
- rst_n_i  in  1  reset; one clock; reset is synchronous and active-low.
- cmd_valid_i  in  1  frame command valid.
- cmd_ready_o  out  1  command accepted when valid&&ready.
- cmd_len_i  in  5  frame length minus one; 0..31 encodes 1..32 bits.
- cmd_cs_i  in  CS_W  chip-select index.
- cmd_lsb_i  in  1  1 = LSB first, 0 = MSB first.
- cmd_tx_i  in  32  transmit word, right-justified in the low len+1 bits.
- cpol_i, cpha_i  in  1 each  SPI mode; static while not idle.
- dly_i  in  8  CS setup and hold length; each is dly_i+1 cycles.
- abort_i  in  1  abort the current frame.
- sck_i  in  1  SPI clock level from the clock generator.
- pos_edge_i, neg_edge_i  in  1 each  one-cycle edge strobes from the clock generator.
- busy_o, st_o, last_o  out  1 each  clock generator controls.
- cs_n_o  out  CS_NUM  active-low chip-selects.
- mosi_o  out  1  serial data out.
- miso_i  in  1  serial data in; sampled directly in the strobe cycle.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response accepted when valid&&ready.
- rsp_rx_o  out  32  received word, right-justified, upper bits zero.

## Operation
- FSM states: IDLE, SETUP, XFER, HOLD, RESP.
- IDLE
  - cmd_ready_o=1.
  - On accept: latch len, cs, lsb, and tx into the shift register; clear the rx register; load the delay counter with dly_i; go to SETUP.
- SETUP
  - cs_n_o[cs]=0.
  - The counter decrements each cycle. At 0, assert st_o for that cycle only and go to XFER.
- XFER
  - busy_o=1.
  - Leading edge = pos_edge_i if cpol_i=0, else neg_edge_i. Trailing edge = the other strobe.
  - Sample strobe: leading edge if cpha_i=0, trailing edge if cpha_i=1.
  - Shift strobe: trailing edge if cpha_i=0. If cpha_i=1, every leading edge except the first of the frame.
  - mosi_o = tx_sr[len] when MSB first, tx_sr[0] when LSB first. It is valid from SETUP entry.
  - A shift advances tx_sr by one bit toward the output position.
  - A sample stores miso_i at bit index (len - count) when MSB first, or index count when LSB first.
  - count increments per sample, 0..len.
  - last_o is set in the cycle after the sample with count==len and stays 1 until XFER exits.
  - Exit to HOLD when last_o=1 and sck_i==cpol_i; reload the delay counter with dly_i.
- HOLD
  - CS stays asserted; busy_o=0.
  - Counter runs down; at 0 go to RESP.
- RESP
  - All cs_n_o=1; rsp_valid_o=1; rsp_rx_o holds the received word.
  - On rsp_ready_i go to IDLE.
- abort_i
  - In SETUP, XFER or HOLD: next cycle the FSM is IDLE; busy_o, st_o and last_o are 0; all CS are deasserted; no response is generated.
  - Ignored in IDLE and RESP.
- Index width: cmd_cs_i >= CS_NUM selects no line; the frame still runs.
- cmd inputs are ignored outside IDLE.

## Timing
- Reset values:
  - State IDLE.
  - cmd_ready_o=1.
  - cs_n_o all 1.
  - busy_o=0, st_o=0, last_o=0.
  - mosi_o=0.
  - rsp_valid_o=0.
  - rsp_rx_o=0.
  - Counters and shift registers 0.
- Reset mid-frame returns to these values on the next edge; no response is produced.
- Command accepted at cycle T: cs_n low from T+1; st_o high at T+1+dly_i; busy_o high from T+2+dly_i.
- HOLD lasts exactly dly_i+1 cycles.
- rsp_valid_o rises on the first cycle after HOLD. rsp_valid_o and rsp_rx_o are stable until the handshake.
- Back-to-back frames: CS is high for at least 2 cycles (RESP plus IDLE accept cycle).
- An edge strobe coincident with abort_i is ignored.
- Strobes outside XFER are ignored.

## Test plan
- Mode 0, MSB first, len=7, tx=0xA5, miso looped to mosi, dly=2, generator div 0 -> 8 sample strobes; rsp_rx=0xA5; st_o exactly 1 cycle; cs_n low for 3 + XFER + 3 cycles.
- Mode 3, LSB first, len=15, tx=0x1234, miso tied 1 -> mosi bit sequence 0,0,1,0,1,1,0,0,0,1,0,0,1,0,0,0; rsp_rx=0xFFFF; sck idle high at HOLD entry.
- Mode 1 and mode 2, len=31, tx=0xDEADBEEF, loopback -> rsp_rx=0xDEADBEEF; no shift on the first leading edge (mode 1, cpol=0: first pos_edge).
- len=0, cs=3, dly=0 -> single bit transferred; cs_n_o=4'b0111 in SETUP through HOLD; SETUP and HOLD are 1 cycle each.
- abort_i asserted on the 3rd sample strobe -> next cycle IDLE, cs_n_o=4'b1111, busy_o=0; rsp_valid_o never rises; the next command completes normally.
- rsp_ready_i held low 10 cycles with cmd_valid_i high -> rsp stable, cmd_ready_o=0 throughout; after the handshake, the command is accepted on the following cycle.
